// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the SDRAM controller command port between VDP, aux requester and refresh
module vram_arbiter #(
    parameter int ADDR_W           = 23,
    parameter int REFRESH_INTERVAL = 810,
    parameter int REFRESH_EARLY    = 405,
    parameter int MAX_VDP_STREAK   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vdp_read,
    input  logic              vdp_write,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [31:0]       vdp_din,
    input  logic [1:0]        vdp_wr_size,
    output logic [31:0]       vdp_dout,
    output logic              vdp_ack,
    output logic              vdp_overrun,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_din,
    input  logic [1:0]        aux_wr_size,
    output logic [31:0]       aux_dout,
    output logic              aux_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_wr_size,
    input  logic [31:0]       mem_dout,
    input  logic              mem_busy,
    input  logic              mem_enabled
);
    localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int STK_W = $clog2(MAX_VDP_STREAK + 1);
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VDP  = 2'd1;
    localparam logic [1:0] G_AUX  = 2'd2;
    localparam logic [1:0] G_REF  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d, sel;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         vdp_dout_q, vdp_dout_d, aux_dout_q, aux_dout_d;
    logic                pend_q, pend_d, pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [31:0]         pend_din_q, pend_din_d;
    logic [1:0]          pend_size_q, pend_size_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STK_W-1:0]    streak_q, streak_d;
    logic                strobe, grant, grant_vdp, grant_aux, issue, finish;

    assign strobe    = vdp_read | vdp_write;
    assign grant     = (state_q == S_IDLE) && mem_enabled && (sel != G_NONE);
    assign grant_vdp = grant && (sel == G_VDP);
    assign grant_aux = grant && (sel == G_AUX);
    assign issue     = state_q == S_ISSUE;
    assign finish    = (state_q == S_WAIT_LO) && !mem_busy;

    // Priority pick: urgent refresh, starved aux, VDP, aux, opportunistic refresh
    always_comb begin
        sel = (cnt_q >= CNT_W'(REFRESH_INTERVAL))                ? G_REF :
              (aux_req && (streak_q == STK_W'(MAX_VDP_STREAK)))  ? G_AUX :
              pend_q                                             ? G_VDP :
              aux_req                                            ? G_AUX :
              (cnt_q >= CNT_W'(REFRESH_EARLY))                   ? G_REF : G_NONE;
    end

    // Access sequencing: issue one pulse, then follow the controller's busy window
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (grant) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT_HI;
            S_WAIT_HI: if (mem_busy) state_d = S_WAIT_LO;
            S_WAIT_LO: if (finish) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Command latch for the winner; refresh leaves address/data untouched so they hold
    always_comb begin
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        size_d  = size_q;
        if (grant) begin
            owner_d = sel;
            wr_d    = (sel == G_VDP) ? pend_wr_q   : (sel == G_AUX) ? aux_wr      : 1'b0;
            addr_d  = (sel == G_VDP) ? pend_addr_q : (sel == G_AUX) ? aux_addr    : addr_q;
            din_d   = (sel == G_VDP) ? pend_din_q  : (sel == G_AUX) ? aux_din     : din_q;
            size_d  = (sel == G_VDP) ? pend_size_q : (sel == G_AUX) ? aux_wr_size : size_q;
        end
    end

    // VDP pending slot: a strobe always wins, a grant frees it, a strobe onto a live slot is an overrun
    always_comb begin
        pend_d      = strobe | (pend_q & ~grant_vdp);
        pend_wr_d   = strobe ? vdp_write   : pend_wr_q;
        pend_addr_d = strobe ? vdp_addr    : pend_addr_q;
        pend_din_d  = strobe ? vdp_din     : pend_din_q;
        pend_size_d = strobe ? vdp_wr_size : pend_size_q;
        overrun_d   = overrun_q | (strobe & pend_q & ~grant_vdp);
    end

    // Refresh age and VDP streak bookkeeping
    always_comb begin
        cnt_d    = mem_refresh ? '0 :
                   (cnt_q == CNT_W'(REFRESH_INTERVAL)) ? cnt_q : cnt_q + 1'b1;
        streak_d = (!aux_req || grant_aux) ? '0 :
                   (grant_vdp && (streak_q != STK_W'(MAX_VDP_STREAK))) ? streak_q + 1'b1 : streak_q;
    end

    // Read data capture on the cycle busy falls, so it is valid alongside the ack
    always_comb begin
        vdp_dout_d = (finish && !wr_q && (owner_q == G_VDP)) ? mem_dout : vdp_dout_q;
        aux_dout_d = (finish && !wr_q && (owner_q == G_AUX)) ? mem_dout : aux_dout_q;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= G_NONE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            size_q      <= '0;
            vdp_dout_q  <= '0;
            aux_dout_q  <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            pend_size_q <= '0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            size_q      <= size_d;
            vdp_dout_q  <= vdp_dout_d;
            aux_dout_q  <= aux_dout_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_din_q  <= pend_din_d;
            pend_size_q <= pend_size_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
        end
    end

    assign mem_read    = issue && (owner_q != G_REF) && !wr_q;
    assign mem_write   = issue && (owner_q != G_REF) && wr_q;
    assign mem_refresh = issue && (owner_q == G_REF);
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign mem_wr_size = size_q;
    assign vdp_ack     = (state_q == S_DONE) && (owner_q == G_VDP);
    assign aux_ack     = (state_q == S_DONE) && (owner_q == G_AUX);
    assign vdp_dout    = vdp_dout_q;
    assign aux_dout    = aux_dout_q;
    assign vdp_overrun = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a simple busy-window controller model
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vdp_read = 1'b0, vdp_write = 1'b0;
    logic [22:0] vdp_addr = '0;
    logic [31:0] vdp_din = '0;
    logic [1:0]  vdp_wr_size = '0;
    logic [31:0] vdp_dout;
    logic        vdp_ack, vdp_overrun;
    logic        aux_req = 1'b0, aux_wr = 1'b0;
    logic [22:0] aux_addr = '0;
    logic [31:0] aux_din = '0;
    logic [1:0]  aux_wr_size = '0;
    logic [31:0] aux_dout;
    logic        aux_ack;
    logic        mem_read, mem_write, mem_refresh;
    logic [22:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_wr_size;
    logic [31:0] mem_dout;
    logic        mem_busy;
    logic        mem_enabled = 1'b1;

    int          total = 0, bad = 0, cyc = 0, rel = 0;
    int          busy_len = 6;
    logic [31:0] rd_data = 32'h0;
    int          ncmd = 0, nmulti = 0;
    logic [1:0]  ck [1024];
    logic [22:0] ca [1024];
    logic [31:0] cd [1024];
    logic [1:0]  cs [1024];
    int          cc [1024];
    int          cf [1024];
    int          nv = 0, na = 0;
    int          vack_cyc [1024];
    logic [31:0] vack_dat [1024];

    vram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vdp_read(vdp_read), .vdp_write(vdp_write), .vdp_addr(vdp_addr),
        .vdp_din(vdp_din), .vdp_wr_size(vdp_wr_size), .vdp_dout(vdp_dout),
        .vdp_ack(vdp_ack), .vdp_overrun(vdp_overrun),
        .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_wr_size(aux_wr_size), .aux_dout(aux_dout), .aux_ack(aux_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr_size(mem_wr_size),
        .mem_dout(mem_dout), .mem_busy(mem_busy), .mem_enabled(mem_enabled)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Controller model: logs each command, busy rises next cycle for busy_len cycles
    initial begin
        mem_busy = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write || mem_refresh) begin
                int idx;
                idx = ncmd;
                if (int'(mem_read) + int'(mem_write) + int'(mem_refresh) > 1) nmulti++;
                ck[idx] = mem_refresh ? 2'd3 : mem_write ? 2'd2 : 2'd1;
                ca[idx] = mem_addr;
                cd[idx] = mem_din;
                cs[idx] = mem_wr_size;
                cc[idx] = cyc;
                ncmd++;
                @(negedge clk);
                mem_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                mem_busy = 1'b0;
                mem_dout = rd_data;
                cf[idx] = cyc;
            end
        end
    end

    // Ack monitor
    initial forever begin
        @(negedge clk);
        if (vdp_ack) begin
            vack_cyc[nv] = cyc;
            vack_dat[nv] = vdp_dout;
            nv++;
        end
        if (aux_ack) na++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        vdp_read = 1'b0; vdp_write = 1'b0; aux_req = 1'b0; aux_wr = 1'b0;
        mem_enabled = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
    endtask

    task automatic vdp_strobe(input bit rd, input bit wr, input logic [22:0] a,
                              input logic [31:0] d, input logic [1:0] s, output int sc);
        vdp_read = rd; vdp_write = wr; vdp_addr = a; vdp_din = d; vdp_wr_size = s;
        sc = cyc;
        @(negedge clk);
        vdp_read = 1'b0; vdp_write = 1'b0;
    endtask

    task automatic wait_vack(input int n, input int budget, output bit ok);
        int k;
        ok = 1'b0;
        k = 0;
        while (!ok && k < budget) begin
            @(negedge clk);
            ok = nv >= n;
            k++;
        end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({vdp_dout, vdp_ack, vdp_overrun, aux_dout, aux_ack, mem_read, mem_write,
             mem_refresh, mem_addr, mem_din, mem_wr_size} !== 127'd0) begin
            bad++; $display("FAIL reset_outputs: outputs not all zero in reset");
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, mem_refresh, vdp_overrun} !== 4'b0) begin
            bad++; $display("FAIL reset_idle: got %b want 0000", {mem_read, mem_write, mem_refresh, vdp_overrun});
        end
    endtask

    task automatic test_single_read;
        int s, b, bv;
        bit ok;
        do_reset;
        busy_len = 6; rd_data = 32'hDEADBEEF;
        b = ncmd; bv = nv;
        vdp_strobe(1, 0, 23'h00123, 32'h0, 2'd0, s);
        wait_vack(bv + 1, 60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_ack_timeout: no vdp_ack"); end
        repeat (20) @(negedge clk);
        total++;
        if (ncmd - b !== 1) begin bad++; $display("FAIL single_cmd_count: got %0d want 1", ncmd - b); end
        total++;
        if (ck[b] !== 2'd1 || ca[b] !== 23'h00123) begin
            bad++; $display("FAIL single_cmd: kind %0d addr %0h want 1 123", ck[b], ca[b]);
        end
        total++;
        if (cc[b] - s !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", cc[b] - s); end
        total++;
        if (nv - bv !== 1) begin bad++; $display("FAIL single_ack_count: got %0d want 1", nv - bv); end
        total++;
        if (vack_dat[bv] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_data: got %h want deadbeef", vack_dat[bv]);
        end
        total++;
        if (vack_cyc[bv] - cf[b] !== 1) begin
            bad++; $display("FAIL single_ack_time: got %0d want 1 after busy fall", vack_cyc[bv] - cf[b]);
        end
    endtask

    task automatic test_back_to_back;
        int s, b, ba, sent, acks, k;
        logic [1:0]  ek [7];
        logic [22:0] ea [7];
        ek = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
        ea = '{23'h100, 23'h101, 23'h102, 23'h103, 23'h7FFFFF, 23'h104, 23'h105};
        do_reset;
        b = ncmd; ba = na;
        aux_wr = 1'b1; aux_addr = 23'h7FFFFF; aux_din = 32'h55AA55AA; aux_wr_size = 2'd2;
        vdp_strobe(1, 0, 23'h100, 32'h0, 2'd0, s);
        aux_req = 1'b1;
        sent = 1; acks = 0; k = 0;
        while (acks < 6 && k < 400) begin
            @(negedge clk);
            vdp_read = 1'b0;
            if (aux_ack) aux_req = 1'b0;
            if (vdp_ack) begin
                acks++;
                if (sent < 6) begin
                    vdp_read = 1'b1;
                    vdp_addr = 23'h100 + 23'(sent);
                    sent++;
                end
            end
            k++;
        end
        vdp_read = 1'b0;
        total++;
        if (acks !== 6) begin bad++; $display("FAIL b2b_acks: got %0d want 6", acks); end
        repeat (5) @(negedge clk);
        total++;
        if (ncmd - b !== 7) begin bad++; $display("FAIL b2b_cmd_count: got %0d want 7", ncmd - b); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ck[b+i] !== ek[i] || ca[b+i] !== ea[i]) begin
                bad++; $display("FAIL b2b_order[%0d]: kind %0d addr %0h want %0d %0h", i, ck[b+i], ca[b+i], ek[i], ea[i]);
            end
        end
        total++;
        if (cd[b+4] !== 32'h55AA55AA || cs[b+4] !== 2'd2) begin
            bad++; $display("FAIL b2b_aux_data: din %h size %0d want 55aa55aa 2", cd[b+4], cs[b+4]);
        end
        total++;
        if (na - ba !== 1) begin bad++; $display("FAIL b2b_aux_ack: got %0d want 1", na - ba); end
        total++;
        if (vdp_overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got 1 want 0"); end
    endtask

    task automatic test_refresh;
        int p1, p2, rn, nref, k, n;
        do_reset;
        p1 = -1; k = 0;
        while (p1 < 0 && k < 500) begin
            @(negedge clk);
            if (mem_refresh) p1 = cyc;
            k++;
        end
        total++;
        if (p1 - rel !== 406) begin bad++; $display("FAIL refresh_early: at %0d want 406 after reset", p1 - rel); end
        vdp_read = 1'b1; vdp_addr = 23'h200;
        p2 = -1; rn = -1; nref = 0; k = 0; n = 1;
        while (rn < 0 && k < 1200) begin
            @(negedge clk);
            vdp_read = 1'b0;
            if (mem_refresh) begin nref++; p2 = cyc; end
            if (mem_read && p2 >= 0 && rn < 0) rn = cyc;
            if (vdp_ack) begin
                vdp_read = 1'b1;
                vdp_addr = 23'h200 + 23'(n);
                n++;
            end
            k++;
        end
        vdp_read = 1'b0;
        total++;
        if (p2 - p1 !== 820) begin bad++; $display("FAIL refresh_urgent: at %0d want 820 after previous", p2 - p1); end
        total++;
        if (nref !== 1) begin bad++; $display("FAIL refresh_count: got %0d want 1", nref); end
        total++;
        if (rn - p2 !== 10) begin bad++; $display("FAIL refresh_preempt: read %0d after refresh want 10", rn - p2); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overrun;
        int s, b, bv, k;
        bit got, ok;
        logic [31:0] adat;
        do_reset;
        rd_data = 32'h0BADF00D;
        b = ncmd; bv = nv;
        aux_wr = 1'b0; aux_addr = 23'h0000AA; aux_req = 1'b1;
        repeat (3) @(negedge clk);
        vdp_strobe(1, 0, 23'h000111, 32'h0, 2'd0, s);
        total++;
        if (vdp_overrun !== 1'b0) begin bad++; $display("FAIL overrun_early: got 1 want 0"); end
        @(negedge clk);
        vdp_strobe(1, 0, 23'h000222, 32'h0, 2'd0, s);
        got = 1'b0; k = 0; adat = '0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (aux_ack) begin aux_req = 1'b0; got = 1'b1; adat = aux_dout; end
            k++;
        end
        wait_vack(bv + 1, 60, ok);
        total++;
        if (!got || !ok) begin bad++; $display("FAIL overrun_acks: aux %0d vdp %0d want 1 1", got, ok); end
        repeat (15) @(negedge clk);
        total++;
        if (vdp_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got 0 want 1"); end
        total++;
        if (ncmd - b !== 2 || ca[b] !== 23'h0000AA || ca[b+1] !== 23'h000222 || ck[b+1] !== 2'd1) begin
            bad++; $display("FAIL overrun_cmds: n %0d addr %0h %0h want 2 aa 222", ncmd - b, ca[b], ca[b+1]);
        end
        total++;
        if (adat !== 32'h0BADF00D) begin bad++; $display("FAIL overrun_aux_data: got %h want 0badf00d", adat); end
        total++;
        if (nv - bv !== 1) begin bad++; $display("FAIL overrun_vack: got %0d want 1", nv - bv); end
    endtask

    task automatic test_write_rearm;
        int s, b;
        do_reset;
        b = ncmd;
        vdp_strobe(1, 1, 23'h000321, 32'hCAFEF00D, 2'd1, s);
        vdp_strobe(1, 0, 23'h000654, 32'h0, 2'd0, s);
        repeat (40) @(negedge clk);
        total++;
        if (ncmd - b !== 2) begin bad++; $display("FAIL rearm_count: got %0d want 2", ncmd - b); end
        total++;
        if (ck[b] !== 2'd2 || ca[b] !== 23'h000321 || cd[b] !== 32'hCAFEF00D || cs[b] !== 2'd1) begin
            bad++; $display("FAIL write_wins: kind %0d addr %0h din %h size %0d want 2 321 cafef00d 1", ck[b], ca[b], cd[b], cs[b]);
        end
        total++;
        if (ck[b+1] !== 2'd1 || ca[b+1] !== 23'h000654) begin
            bad++; $display("FAIL rearm_cmd: kind %0d addr %0h want 1 654", ck[b+1], ca[b+1]);
        end
        total++;
        if (vdp_overrun !== 1'b0) begin bad++; $display("FAIL rearm_overrun: got 1 want 0"); end
    endtask

    task automatic test_enable;
        int s, b, pulses, k;
        bit got;
        do_reset;
        mem_enabled = 1'b0;
        b = ncmd;
        aux_wr = 1'b1; aux_addr = 23'h000333; aux_din = 32'h11112222; aux_wr_size = 2'd3; aux_req = 1'b1;
        vdp_strobe(1, 0, 23'h000444, 32'h0, 2'd0, s);
        pulses = 0;
        repeat (830) begin
            @(negedge clk);
            if (mem_read || mem_write || mem_refresh) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL enable_gate: got %0d pulses want 0", pulses); end
        mem_enabled = 1'b1;
        got = 1'b0; k = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (aux_ack) begin aux_req = 1'b0; got = 1'b1; end
            k++;
        end
        repeat (10) @(negedge clk);
        total++;
        if (ncmd - b !== 3) begin bad++; $display("FAIL enable_count: got %0d want 3", ncmd - b); end
        total++;
        if (ck[b] !== 2'd3 || ck[b+1] !== 2'd1 || ca[b+1] !== 23'h000444 || ck[b+2] !== 2'd2 || ca[b+2] !== 23'h000333) begin
            bad++; $display("FAIL enable_order: kinds %0d %0d %0d addr %0h %0h want 3 1 2 444 333", ck[b], ck[b+1], ck[b+2], ca[b+1], ca[b+2]);
        end
    endtask

    task automatic test_reset_mid_wait;
        int s, b, bv;
        bit ok;
        do_reset;
        rd_data = 32'h12345678;
        b = ncmd; bv = nv;
        vdp_strobe(1, 0, 23'h000555, 32'h0, 2'd0, s);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({vdp_dout, vdp_ack, vdp_overrun, aux_dout, aux_ack, mem_read, mem_write,
             mem_refresh, mem_addr, mem_din, mem_wr_size} !== 127'd0) begin
            bad++; $display("FAIL midreset_outputs: mem_addr %0h not all zero", mem_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        total++;
        if (nv !== bv || ncmd - b !== 1) begin
            bad++; $display("FAIL midreset_abandon: acks %0d cmds %0d want 0 1", nv - bv, ncmd - b);
        end
        vdp_strobe(1, 0, 23'h000666, 32'h0, 2'd0, s);
        wait_vack(bv + 1, 60, ok);
        total++;
        if (!ok || ca[b+1] !== 23'h000666 || vack_dat[bv] !== 32'h12345678) begin
            bad++; $display("FAIL midreset_next: ack %0d addr %0h data %h want 1 666 12345678", ok, ca[b+1], vack_dat[bv]);
        end
    endtask

    task automatic test_pulse_exclusive;
        total++;
        if (nmulti !== 0) begin bad++; $display("FAIL pulse_exclusive: %0d overlapping pulses want 0", nmulti); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_back_to_back;
        test_refresh;
        test_overrun;
        test_write_rearm;
        test_enable;
        test_reset_mid_wait;
        test_pulse_exclusive;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits between the VDP memory port and the SDRAM memory controller.
- Shares the controller's single command port between three sources: the VDP (highest priority), an auxiliary requester (a future blitter or direct CPU VRAM port), and a self-timed refresh scheduler.
- Issues one-cycle read/write/refresh command pulses to the controller and returns read data and acknowledges to the owning requester.

Parameters:
- ADDR_W, 23, address width of VRAM word address
- REFRESH_INTERVAL, 810, clk cycles after last refresh at which refresh becomes urgent
- REFRESH_EARLY, 405, clk cycles after last refresh at which opportunistic refresh is allowed
- MAX_VDP_STREAK, 4, consecutive VDP grants allowed while aux is pending before aux wins one slot

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vdp_read  in  1  one-cycle VDP read strobe
- vdp_write  in  1  one-cycle VDP write strobe
- vdp_addr  in  ADDR_W  VDP address
- vdp_din  in  32  VDP write data
- vdp_wr_size  in  2  VDP write size code
- vdp_dout  out  32  VDP read data
- vdp_ack  out  1  one-cycle completion pulse for VDP access
- vdp_overrun  out  1  sticky: VDP strobe arrived while VDP request still pending
- aux_req  in  1  aux request, held high until aux_ack
- aux_wr  in  1  aux direction, 1 = write
- aux_addr  in  ADDR_W  aux address
- aux_din  in  32  aux write data
- aux_wr_size  in  2  aux write size code
- aux_dout  out  32  aux read data
- aux_ack  out  1  one-cycle completion pulse for aux access
- mem_read  out  1  read command pulse to controller
- mem_write  out  1  write command pulse to controller
- mem_refresh  out  1  refresh command pulse to controller
- mem_addr  out  ADDR_W  command address
- mem_din  out  32  command write data
- mem_wr_size  out  2  command write size
- mem_dout  in  32  controller read data
- mem_busy  in  1  controller busy; rises the cycle after a command, falls when the access completes
- mem_enabled  in  1  controller initialised; no commands are issued while low

Behaviour:
- Reset (async, reset_n low): every output 0. vdp_overrun cleared. Pending VDP request, refresh counter and streak counter cleared. FSM goes to IDLE. Reset mid-access abandons the access; no ack is produced.
- VDP strobe capture: vdp_read or vdp_write latches addr, data, size and direction into a pending register. If both strobe in the same cycle, write wins. If a new strobe arrives while pending is set, it overwrites pending and sets vdp_overrun, which stays set until reset.
- Refresh counter: increments each clk and saturates at REFRESH_INTERVAL. It clears in the cycle mem_refresh is issued.
- FSM states:
  - IDLE: if mem_enabled, select a grant by priority and go to ISSUE. Otherwise stay, issuing nothing.
  - ISSUE: drive exactly one of mem_read, mem_write or mem_refresh high for 1 cycle, with mem_addr, mem_din and mem_wr_size stable. Go to WAIT.
  - WAIT: wait for mem_busy high, then for mem_busy low. On the falling cycle, go to DONE.
  - DONE: for reads, register mem_dout into vdp_dout or aux_dout. Pulse the owner's ack for 1 cycle. Return to IDLE.
- Grant priority, evaluated in IDLE:
  1. Refresh, if counter ≥ REFRESH_INTERVAL.
  2. Aux, if aux_req and streak = MAX_VDP_STREAK.
  3. VDP pending.
  4. aux_req.
  5. Refresh, if counter ≥ REFRESH_EARLY.
- Streak counter: increments on each VDP grant while aux_req is high. Clears on aux grant or when aux_req is low.
- Pending clear: the VDP pending register clears when granted. A strobe in the same cycle as the grant re-arms pending and does not set overrun.
- Latency: a strobe in cycle N with FSM idle gives pending in N+1, command pulse in N+2, and ack one cycle after mem_busy falls. Command outputs other than the pulses hold their last values between commands.
- mem_enabled falling during WAIT: the current access completes normally. No new grant is made until mem_enabled is high again.
- Aux data: aux_addr, aux_din and aux_wr_size are sampled in the grant cycle. aux_req must drop the cycle after aux_ack; if it stays high, it is a new request.

Test Plan:
- Idle VDP read at addr 0x00123; controller busy for 6 cycles returning 0xDEADBEEF -> exactly 1 mem_read pulse with mem_addr=0x00123, then vdp_ack pulse with vdp_dout=0xDEADBEEF one cycle after busy falls.
- Hold aux_req write (0x7FFFFF, 0x55AA55AA, size 2) while issuing 6 back-to-back VDP reads -> VDP granted 4 times, then aux write issued, then remaining VDP reads; aux_ack once.
- No traffic for 405 cycles -> opportunistic mem_refresh; continuous VDP traffic for 810+ cycles -> refresh preempts the next VDP grant and the counter restarts.
- Two VDP strobes 2 cycles apart while an aux access is in WAIT -> vdp_overrun=1, only the second address is issued.
- mem_enabled=0 with all requests pending -> no command pulses; raise mem_enabled -> commands resume in priority order.
- Assert reset_n low during WAIT of a VDP read -> all outputs 0 immediately, no vdp_ack after release, the next strobe is handled normally.
